// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, parity modes,
// default frame constants and a parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam bit PARITY_MODE_EVEN = 1'b0;
   localparam bit PARITY_MODE_ODD  = 1'b1;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;

   // Narrower bytes are zero-extended, which leaves the XOR unchanged.
   function automatic logic uart_parity(input logic [7:0] d,
                                        input logic       odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a host byte source and the transmitter.
// data_in/data_valid flow master->slave, data_ready slave->master.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_in;
   logic                 data_valid;
   logic                 data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/uart_tx_hold.sv
// One-entry holding register behind the valid/ready handshake.
// Ports: clk, reset (async, active-low), up (slave handshake),
// drain_i (FSM takes the byte), full_o, data_o (held byte).
module uart_tx_hold #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_tx_if.slave             up,
   input  logic                 drain_i,
   output logic                 full_o,
   output logic [DATA_BITS-1:0] data_o
);

   logic                 full_q, full_d;
   logic [DATA_BITS-1:0] data_q, data_d;

   // Accept only while empty, drain only while full: never both.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (drain_i) begin
         full_d = 1'b0;
      end
      if (up.data_valid && !full_q) begin
         full_d = 1'b1;
         data_d = up.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign up.data_ready = !full_q;
   assign full_o        = full_q;
   assign data_o        = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop bits.
// Ports: clk, reset (async, active-low), tick (baud enable),
// host (byte handshake), tx (line), busy, tx_done (end-of-frame pulse).
module uart_tx import uart_pkg::*; #(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = PARITY_MODE_EVEN,
   parameter int STOP_BITS  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   uart_tx_if.slave host,
   output logic tx,
   output logic busy,
   output logic tx_done
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;

   logic                 hold_full;
   logic [DATA_BITS-1:0] hold_data;
   logic                 bit_end;
   logic                 frame_end;
   logic                 load;

   uart_tx_hold #(.DATA_BITS(DATA_BITS)) u_hold (
      .clk     (clk),
      .reset   (reset),
      .up      (host),
      .drain_i (load),
      .full_o  (hold_full),
      .data_o  (hold_data)
   );

   assign bit_end   = tick && (tick_cnt_q == TICK_LAST);
   assign frame_end = (state_q == STOP) && bit_end
                   && (bit_cnt_q == STOP_LAST);
   // A waiting byte starts from IDLE, or straight off the last stop bit.
   assign load = hold_full && tick
              && ((state_q == IDLE) || frame_end);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_d       = tx_q;
      done_d     = 1'b0;

      if (tick && (state_q != IDLE)) begin
         tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
         end
         START: begin
            if (bit_end) begin
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  if (PARITY_EN) begin
                     tx_d    = par_q;
                     state_d = PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_d      = 1'b1;
               bit_cnt_d = '0;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (frame_end) begin
               done_d  = 1'b1;
               tx_d    = 1'b1;
               state_d = IDLE;
            end else if (bit_end) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (load) begin
         shift_d    = hold_data;
         par_d      = uart_parity(8'(hold_data), PARITY_ODD);
         tx_d       = 1'b0;
         tick_cnt_d = '0;
         bit_cnt_d  = '0;
         state_d    = START;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = done_q;
   assign busy    = (state_q != IDLE) | hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four frame configurations, per-tick line
// scoreboard, handshake, parity, stop length and reset-abort steps.
module tb_uart_tx;

   localparam int OS = 4;
   // Per-instance frame format: parity enable, odd parity, two stops.
   localparam logic [3:0] PEN_M   = 4'b0110;
   localparam logic [3:0] ODD_M   = 4'b0100;
   localparam logic [3:0] STOP2_M = 4'b1000;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       tick_en;
   logic       tick_force;
   logic [7:0] din;
   logic [3:0] dval;
   logic [3:0] ready_w;
   logic [3:0] tx_w;
   logic [3:0] busy_w;
   logic [3:0] done_w;

   int sel;
   int n_cmp;
   int n_bad;
   int popped;
   int done_cnt;
   int low_cnt;
   bit armed;
   bit mon_en;

   // Expected {tx, tx_done} seen after each tick edge of a frame.
   logic [1:0] exp_q[$];

   uart_tx_if #(.DATA_BITS(8)) if0 ();
   uart_tx_if #(.DATA_BITS(8)) if1 ();
   uart_tx_if #(.DATA_BITS(8)) if2 ();
   uart_tx_if #(.DATA_BITS(8)) if3 ();

   assign if0.data_in = din;
   assign if1.data_in = din;
   assign if2.data_in = din;
   assign if3.data_in = din;
   assign if0.data_valid = dval[0];
   assign if1.data_valid = dval[1];
   assign if2.data_valid = dval[2];
   assign if3.data_valid = dval[3];
   assign ready_w[0] = if0.data_ready;
   assign ready_w[1] = if1.data_ready;
   assign ready_w[2] = if2.data_ready;
   assign ready_w[3] = if3.data_ready;

   uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b0),
             .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .tick(tick), .host(if0),
      .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

   uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b1),
             .PARITY_ODD(1'b0), .STOP_BITS(1)) u1 (
      .clk(clk), .reset(reset), .tick(tick), .host(if1),
      .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

   uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b1),
             .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
      .clk(clk), .reset(reset), .tick(tick), .host(if2),
      .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

   uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b0),
             .PARITY_ODD(1'b0), .STOP_BITS(2)) u3 (
      .clk(clk), .reset(reset), .tick(tick), .host(if3),
      .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // tick changes 1ns after negedge, so at a negedge it still shows
   // whether the preceding posedge was a tick edge.
   initial begin
      tick = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         tick = tick_force | (tick_en & ($urandom_range(0, 1) == 1));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line monitor: sync on the start bit, then pop one entry per tick.
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (done_w[sel] === 1'b1) done_cnt++;
         if (tx_w[sel] === 1'b0) low_cnt++;
         if (mon_en && tick) begin
            if (!armed && exp_q.size() > 0 && tx_w[sel] === 1'b0)
               armed = 1'b1;
            if (armed) begin
               e = exp_q.pop_front();
               check("slot", {30'd0, tx_w[sel], done_w[sel]}, {30'd0, e});
               popped++;
               if (exp_q.size() == 0) armed = 1'b0;
            end
         end
      end
   end

   task automatic push_frame(input int c, input logic [7:0] b);
      logic fb[$];
      logic d0;
      d0 = 1'b0;
      // Back-to-back: the pending end-of-frame slot is this start slot.
      if (exp_q.size() > 0) begin
         void'(exp_q.pop_back());
         d0 = 1'b1;
      end
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(b[i]);
      if (PEN_M[c]) fb.push_back((^b) ^ ODD_M[c]);
      fb.push_back(1'b1);
      if (STOP2_M[c]) fb.push_back(1'b1);
      foreach (fb[k]) begin
         for (int t = 0; t < OS; t++) begin
            exp_q.push_back({fb[k], d0});
            d0 = 1'b0;
         end
      end
      exp_q.push_back(2'b11);
   endtask

   task automatic send(input logic [7:0] b);
      int k;
      push_frame(sel, b);
      @(negedge clk);
      din = b;
      dval[sel] = 1'b1;
      k = 0;
      while (!ready_w[sel] && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("accept_timeout", 32'(k < 3000), 1);
      @(negedge clk);
      dval[sel] = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(k < 5000), 1);
      exp_q.delete();
      armed = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int d0;
      int acc;
      int p0;
      int k;
      n_cmp = 0; n_bad = 0; popped = 0; done_cnt = 0; low_cnt = 0;
      armed = 1'b0; mon_en = 1'b1; sel = 0;
      reset = 1'b0; tick_en = 1'b0; tick_force = 1'b0;
      din = '0; dval = '0;

      repeat (3) @(negedge clk);
      check("rst_tx", {31'd0, tx_w[0]}, 1);
      check("rst_busy", {31'd0, busy_w[0]}, 0);
      check("rst_ready", {31'd0, ready_w[0]}, 1);
      check("rst_done", {31'd0, done_w[0]}, 0);
      reset = 1'b1;
      tick_en = 1'b1;
      repeat (3) @(negedge clk);

      // Single 0x55 frame.
      d0 = done_cnt;
      send(8'h55);
      check("single_ready_low", {31'd0, ready_w[0]}, 0);
      check("single_busy", {31'd0, busy_w[0]}, 1);
      wait_drain("single_drain");
      check("single_done_cnt", 32'(done_cnt - d0), 1);
      check("single_idle_busy", {31'd0, busy_w[0]}, 0);

      // Back-to-back 0xA5 then 0x3C, zero gap.
      d0 = done_cnt;
      send(8'hA5);
      check("b2b_ready_low", {31'd0, ready_w[0]}, 0);
      send(8'h3C);
      check("b2b_busy", {31'd0, busy_w[0]}, 1);
      wait_drain("b2b_drain");
      check("b2b_done_cnt", 32'(done_cnt - d0), 2);

      // Even parity, odd parity, two stop bits.
      sel = 1;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      send(8'h07);
      wait_drain("par_even_drain");
      check("par_even_done", 32'(done_cnt - d0), 1);
      sel = 2;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      send(8'h07);
      wait_drain("par_odd_drain");
      check("par_odd_done", 32'(done_cnt - d0), 1);
      sel = 3;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      send(8'hFF);
      wait_drain("stop2_drain");
      check("stop2_done", 32'(done_cnt - d0), 1);

      // Valid held for 100 clks with no ticks.
      sel = 0;
      tick_en = 1'b0;
      repeat (3) @(negedge clk);
      acc = 0;
      din = 8'h96;
      dval[0] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (ready_w[0]) acc++;
         @(negedge clk);
      end
      dval[0] = 1'b0;
      check("notick_accepts", 32'(acc), 1);
      check("notick_tx", {31'd0, tx_w[0]}, 1);
      check("notick_busy", {31'd0, busy_w[0]}, 1);
      push_frame(0, 8'h96);
      tick_force = 1'b1;
      @(negedge clk);
      tick_force = 1'b0;
      check("first_tick_start", {31'd0, tx_w[0]}, 0);
      tick_en = 1'b1;
      wait_drain("notick_drain");

      // Reset during the fourth data bit with a second byte held.
      p0 = popped;
      send(8'h0F);
      send(8'h81);
      k = 0;
      while (popped < p0 + 16 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("midframe_timeout", 32'(k < 3000), 1);
      mon_en = 1'b0;
      exp_q.delete();
      armed = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("abort_tx", {31'd0, tx_w[0]}, 1);
      check("abort_busy", {31'd0, busy_w[0]}, 0);
      check("abort_ready", {31'd0, ready_w[0]}, 1);
      @(negedge clk);
      reset = 1'b1;
      d0 = low_cnt;
      repeat (60) @(negedge clk);
      check("abort_no_frame", 32'(low_cnt - d0), 0);
      check("abort_idle_busy", {31'd0, busy_w[0]}, 0);
      mon_en = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog no_finish");
      $fatal(1, "watchdog");
   end

endmodule
